// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_pkg
// Description : Shared sizes and sequencer state encoding for the 4-4-2 MLP.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

  localparam int DATA_W = 5;
  localparam int OUT_W  = 17;
  localparam int N_IN   = 4;
  localparam int N_HID  = 4;
  localparam int N_OUT  = 2;
  localparam int N_W    = 28;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mlp_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mlp_seq_fifo
// Description : Synchronous FIFO; a pop frees its slot for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_seq_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == c_CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mlp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mlp_seq_ctrl
// Description : Weight bank, job issue and credit-based result capture for the
//               4-4-2 MLP datapath. Define MLP_SEQ_PERF_EN for perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_seq_ctrl
  import mlp_pkg::*;
#(
  parameter int DATA_W    = mlp_pkg::DATA_W,
  parameter int OUT_W     = mlp_pkg::OUT_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_en,
  input  logic                    cfg_we,
  input  logic [4:0]              cfg_addr,
  input  logic [DATA_W-1:0]       cfg_wdata,
  output logic                    cfg_err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_IN*DATA_W-1:0]  s_x,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_W-1:0]        m_out0,
  output logic [OUT_W-1:0]        m_out1,
  output logic                    dp_in_ready,
  output logic [N_IN*DATA_W-1:0]  dp_x,
  output logic [N_W*DATA_W-1:0]   dp_w,
  input  logic [OUT_W-1:0]        dp_out0,
  input  logic [OUT_W-1:0]        dp_out1,
  input  logic                    dp_out_ready,
  output logic                    busy,
  output logic [15:0]             perf_jobs,
  output logic [15:0]             perf_stall
);

  localparam int c_CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int c_CRED_W = c_CNT_W + 1;

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [DATA_W-1:0]      r_wbank [N_W];
  logic [N_IN*DATA_W-1:0] r_dp_x;
  logic                   r_dp_in_ready;
  logic                   r_cfg_err;
  logic [c_CNT_W-1:0]     r_inflight;
  logic [c_CNT_W-1:0]     w_inflight_nxt;
  logic [c_CNT_W-1:0]     w_fifo_count;
  logic [c_CNT_W-1:0]     w_fifo_count_nxt;
  logic [c_CRED_W-1:0]    w_credits;
  logic [2*OUT_W-1:0]     w_fifo_rdata;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_pop;
  logic                   w_addr_ok;

  assign w_accept  = s_valid && s_ready;
  assign w_capture = dp_out_ready && (r_inflight != '0);
  assign w_pop     = m_valid && m_ready;
  assign w_credits = c_CRED_W'(r_inflight) + c_CRED_W'(w_fifo_count);
  assign w_addr_ok = (cfg_addr < 5'(N_W));

  // Look-ahead counts let DRAIN fall back to CFG on the very edge of the last pop.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_accept && !w_capture)      w_inflight_nxt = r_inflight + 1'b1;
    else if (!w_accept && w_capture) w_inflight_nxt = r_inflight - 1'b1;
    w_fifo_count_nxt = w_fifo_count;
    if (w_capture && !w_pop)         w_fifo_count_nxt = w_fifo_count + 1'b1;
    else if (!w_capture && w_pop)    w_fifo_count_nxt = w_fifo_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CFG;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CFG:   if (run_en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!run_en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (run_en) w_state_nxt = ST_RUN;
        else if ((w_inflight_nxt == '0) && (w_fifo_count_nxt == '0)) w_state_nxt = ST_CFG;
      end
      default:  w_state_nxt = ST_CFG;
    endcase
  end

  // The full term is redundant with the credit test; it keeps the FIFO flag honest.
  always_comb begin
    busy    = (r_state != ST_CFG);
    s_ready = (r_state == ST_RUN) && (w_credits < c_CRED_W'(OUT_DEPTH)) && !w_fifo_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_W; i++) r_wbank[i] <= '0;
      r_dp_x        <= '0;
      r_dp_in_ready <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_inflight    <= '0;
    end else begin
      if (cfg_we && w_addr_ok && (r_state == ST_CFG)) r_wbank[cfg_addr] <= cfg_wdata;
      if (w_accept) r_dp_x <= s_x;
      r_dp_in_ready <= w_accept;
      r_inflight    <= w_inflight_nxt;
      if ((cfg_we && (!w_addr_ok || (r_state != ST_CFG))) ||
          (dp_out_ready && (r_inflight == '0)))
        r_cfg_err <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_W; gi++) begin : g_dp_w
    assign dp_w[gi*DATA_W +: DATA_W] = r_wbank[gi];
  end

  assign dp_x        = r_dp_x;
  assign dp_in_ready = r_dp_in_ready;
  assign cfg_err     = r_cfg_err;

  mlp_seq_fifo #(
    .WIDTH (2*OUT_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_capture),
    .wdata ({dp_out1, dp_out0}),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign m_valid = !w_fifo_empty;
  assign m_out0  = w_fifo_rdata[OUT_W-1:0];
  assign m_out1  = w_fifo_rdata[2*OUT_W-1:OUT_W];

`ifdef MLP_SEQ_PERF_EN
  logic [15:0] r_perf_jobs;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_jobs  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept) r_perf_jobs <= r_perf_jobs + 16'd1;
      if ((r_state == ST_RUN) && s_valid && !s_ready) r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_jobs  = r_perf_jobs;
  assign perf_stall = r_perf_stall;
`else
  assign perf_jobs  = '0;
  assign perf_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mlp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_seq_ctrl
// Description : Directed self-checking bench for mlp_seq_ctrl with a behavioural
//               4-4-2 ReLU datapath model (two-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_seq_ctrl;

  localparam int DW = 5;
  localparam int OW = 17;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_en = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_err;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [19:0]   s_x = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [OW-1:0] m_out0, m_out1;
  logic          dp_in_ready;
  logic [19:0]   dp_x;
  logic [139:0]  dp_w;
  logic [OW-1:0] dp_out0, dp_out1;
  logic          dp_out_ready;
  logic          busy;
  logic [15:0]   perf_jobs, perf_stall;

  int vectors = 0;
  int miscompares = 0;
  int n_pulses = 0;
  int jobs_since_rst = 0;
  int wv [28];

  mlp_seq_ctrl #(.DATA_W(DW), .OUT_W(OW), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .m_valid(m_valid), .m_ready(m_ready), .m_out0(m_out0), .m_out1(m_out1),
    .dp_in_ready(dp_in_ready), .dp_x(dp_x), .dp_w(dp_w), .dp_out0(dp_out0),
    .dp_out1(dp_out1), .dp_out_ready(dp_out_ready), .busy(busy),
    .perf_jobs(perf_jobs), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Datapath model: hidden = ReLU(x*w), out = hidden*w, 17-bit wrap.
  function automatic logic [2*OW-1:0] dp_model(input logic [19:0] x, input logic [139:0] w);
    int xv [4];
    int h [4];
    int o [2];
    for (int i = 0; i < 4; i++) xv[i] = int'($signed(x[(3-i)*5 +: 5]));
    for (int j = 0; j < 4; j++) begin
      h[j] = 0;
      for (int i = 0; i < 4; i++) h[j] += xv[i] * int'($signed(w[(j*4+i)*5 +: 5]));
      if (h[j] < 0) h[j] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      o[k] = 0;
      for (int j = 0; j < 4; j++) o[k] += h[j] * int'($signed(w[(16+k*4+j)*5 +: 5]));
    end
    return {17'(o[1]), 17'(o[0])};
  endfunction

  logic          p1_v;
  logic [2*OW-1:0] p1_d;
  always @(posedge clk) begin
    if (rst) begin
      p1_v <= 1'b0;
      dp_out_ready <= 1'b0;
      p1_d <= '0;
      dp_out0 <= '0;
      dp_out1 <= '0;
    end else begin
      p1_v <= dp_in_ready;
      p1_d <= dp_model(dp_x, dp_w);
      dp_out_ready <= p1_v;
      {dp_out1, dp_out0} <= p1_d;
    end
  end

  always @(negedge clk) if (dp_in_ready) n_pulses++;

  function automatic logic [19:0] mkx(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w();
    for (int k = 0; k < 28; k++) begin
      cfg_we = 1'b1; cfg_addr = 5'(k); cfg_wdata = 5'(wv[k]);
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic simple_bank();
    for (int k = 0; k < 28; k++) wv[k] = 0;
    wv[0] = 1; wv[16] = 1; wv[20] = 2;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; tick(); rst = 1'b0;
    jobs_since_rst = 0;
  endtask

  task automatic wait_idle();
    int t;
    run_en = 1'b0; t = 0;
    while (busy && t < 50) begin tick(); t++; end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic send_one(input logic [19:0] x);
    int t;
    s_valid = 1'b1; s_x = x; t = 0;
    while (!s_ready && t < 20) begin tick(); t++; end
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++; $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
    end else jobs_since_rst++;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_job(input string name, input logic [19:0] x, input int e0, input int e1);
    int t;
    m_ready = 1'b0; run_en = 1'b1; tick();
    send_one(x);
    vectors++;
    if (dp_in_ready !== 1'b1 || dp_x !== x) begin
      miscompares++; $display("FAIL %s_issue: dp_in_ready=%b dp_x=%h required 1 %h", name, dp_in_ready, dp_x, x);
    end
    tick();
    vectors++;
    if (dp_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL %s_pulse_width: dp_in_ready=%b required 0", name, dp_in_ready);
    end
    t = 0;
    while (!m_valid && t < 20) begin tick(); t++; end
    vectors++;
    if (m_valid !== 1'b1 || $signed(m_out0) != e0 || $signed(m_out1) != e1) begin
      miscompares++;
      $display("FAIL %s_result: m_valid=%b out0=%0d out1=%0d required 1 %0d %0d", name, m_valid, $signed(m_out0), $signed(m_out1), e0, e1);
    end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 || dp_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: mv=%b sr=%b busy=%b err=%b dpr=%b required all 0", m_valid, s_ready, busy, cfg_err, dp_in_ready);
    end
    vectors++;
    if (dp_x !== '0 || dp_w !== '0 || m_out0 !== '0 || m_out1 !== '0 || perf_jobs !== '0 || perf_stall !== '0) begin
      miscompares++; $display("FAIL reset_data: dp_x=%h dp_w=%h out0=%h out1=%h perf=%h/%h required all 0", dp_x, dp_w, m_out0, m_out1, perf_jobs, perf_stall);
    end
  endtask

  task automatic test_reference();
    wv = '{3, 2, 13, -6, -9, 1, -4, 14, 3, 6, -15, 15, 9, -10, 15, -10,
           0, -1, 3, -11, -12, -15, -15, 6, 0, 0, 0, 0};
    load_w();
    vectors++;
    if (dp_w[4:0] !== 5'd3 || dp_w[119:115] !== 5'd6 || dp_w[139:120] !== 20'd0) begin
      miscompares++; $display("FAIL weight_load: w0=%0d w23=%0d hi=%h required 3 6 0", dp_w[4:0], dp_w[119:115], dp_w[139:120]);
    end
    do_job("reference", mkx(4, 2, 4, 1), -726, -348);
  endtask

  task automatic test_max_magnitude();
    for (int k = 0; k < 28; k++) wv[k] = 15;
    load_w();
    do_job("max_pos", mkx(15, 15, 15, 15), 54000, 54000);
    for (int k = 0; k < 28; k++) wv[k] = -16;
    load_w();
    do_job("max_neg", mkx(-16, -16, -16, -16), -65536, -65536);
  endtask

  task automatic test_backpressure();
    int sent, p0;
    int got0 [$];
    int got1 [$];
    simple_bank(); load_w();
    m_ready = 1'b0; run_en = 1'b1; tick();
    p0 = n_pulses; sent = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = (sent < 6); s_x = mkx(sent + 1, 0, 0, 0);
      if (s_valid && s_ready) begin sent++; jobs_since_rst++; end
      tick();
    end
    vectors++;
    if (sent != 4 || s_ready !== 1'b0 || n_pulses - p0 != 4) begin
      miscompares++; $display("FAIL bp_stall: accepts=%0d s_ready=%b pulses=%0d required 4 0 4", sent, s_ready, n_pulses - p0);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 60 && got0.size() < 6; c++) begin
      s_valid = (sent < 6); s_x = mkx(sent + 1, 0, 0, 0);
      if (s_valid && s_ready) begin sent++; jobs_since_rst++; end
      if (m_valid) begin got0.push_back(int'($signed(m_out0))); got1.push_back(int'($signed(m_out1))); end
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    vectors++;
    if (sent != 6 || got0.size() != 6 || n_pulses - p0 != 6) begin
      miscompares++; $display("FAIL bp_release: accepts=%0d results=%0d pulses=%0d required 6 6 6", sent, got0.size(), n_pulses - p0);
    end
    for (int k = 0; k < got0.size(); k++) begin
      vectors++;
      if (got0[k] != k + 1 || got1[k] != 2 * (k + 1)) begin
        miscompares++; $display("FAIL bp_order[%0d]: out0=%0d out1=%0d required %0d %0d", k, got0[k], got1[k], k + 1, 2 * (k + 1));
      end
    end
`ifdef MLP_SEQ_PERF_EN
    vectors++;
    if (perf_jobs !== 16'(jobs_since_rst) || perf_stall == 16'd0) begin
      miscompares++; $display("FAIL perf_counts: jobs=%0d stall=%0d required %0d and nonzero", perf_jobs, perf_stall, jobs_since_rst);
    end
`else
    vectors++;
    if (perf_jobs !== 16'd0 || perf_stall !== 16'd0) begin
      miscompares++; $display("FAIL perf_tied: jobs=%0d stall=%0d required 0 0", perf_jobs, perf_stall);
    end
`endif
    wait_idle();
  endtask

  task automatic test_drain();
    simple_bank(); load_w();
    m_ready = 1'b0; run_en = 1'b1; tick();
    send_one(mkx(1, 0, 0, 0));
    send_one(mkx(2, 0, 0, 0));
    send_one(mkx(3, 0, 0, 0));
    run_en = 1'b0; tick();
    vectors++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++; $display("FAIL drain_enter: busy=%b s_ready=%b required 1 0", busy, s_ready);
    end
    for (int c = 0; c < 10; c++) tick();
    vectors++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      miscompares++; $display("FAIL drain_hold: busy=%b m_valid=%b required 1 1", busy, m_valid);
    end
    for (int k = 0; k < 3; k++) begin
      m_ready = 1'b1;
      vectors++;
      if (m_valid !== 1'b1 || $signed(m_out0) != k + 1) begin
        miscompares++; $display("FAIL drain_pop[%0d]: m_valid=%b out0=%0d required 1 %0d", k, m_valid, $signed(m_out0), k + 1);
      end
      tick();
      vectors++;
      if (busy !== (k < 2)) begin
        miscompares++; $display("FAIL drain_busy[%0d]: busy=%b required %b", k, busy, (k < 2));
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_cfg_protect();
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++; $display("FAIL cfg_err_clean: cfg_err=%b required 0", cfg_err);
    end
    run_en = 1'b1; tick();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 5'd7; tick(); cfg_we = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1 || dp_w[4:0] !== 5'd1) begin
      miscompares++; $display("FAIL cfg_in_run: cfg_err=%b w0=%0d required 1 1", cfg_err, dp_w[4:0]);
    end
    wait_idle();
    pulse_rst();
    vectors++;
    if (cfg_err !== 1'b0 || dp_w !== '0) begin
      miscompares++; $display("FAIL cfg_err_rst: cfg_err=%b dp_w=%h required 0 0", cfg_err, dp_w);
    end
    cfg_we = 1'b1; cfg_addr = 5'd30; cfg_wdata = 5'd9; tick(); cfg_we = 1'b0;
    tick(); tick();
    vectors++;
    if (cfg_err !== 1'b1 || dp_w !== '0) begin
      miscompares++; $display("FAIL cfg_bad_addr: cfg_err=%b dp_w=%h required 1 0", cfg_err, dp_w);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    pulse_rst();
    simple_bank(); load_w();
    m_ready = 1'b0; run_en = 1'b1; tick();
    send_one(mkx(1, 0, 0, 0));
    send_one(mkx(2, 0, 0, 0));
    for (int c = 0; c < 10; c++) tick();
    vectors++;
    if (m_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_prefill: m_valid=%b required 1", m_valid);
    end
    pulse_rst();
    run_en = 1'b0;
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || perf_jobs !== 16'd0 || cfg_err !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: mv=%b busy=%b sr=%b jobs=%0d err=%b required 0 0 0 0 0", m_valid, busy, s_ready, perf_jobs, cfg_err);
    end
    run_en = 1'b1; tick();
    acc = 0;
    for (int c = 0; c < 15; c++) begin
      s_valid = 1'b1; s_x = mkx(c + 1, 0, 0, 0);
      if (s_ready) acc++;
      tick();
    end
    s_valid = 1'b0;
    vectors++;
    if (acc != OD) begin
      miscompares++; $display("FAIL mid_credits: accepts=%0d required %0d", acc, OD);
    end
    run_en = 1'b0;
    pulse_rst();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reference();
    test_max_magnitude();
    test_backpressure();
    test_drain();
    test_cfg_protect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
